// File: rtl/palette_pixel_pipe.sv
// Three-stage pixel path: draw coordinate -> scrolled framebuffer address -> palette index -> RGB.
// Scroll offsets only change on a frame strobe so a frame is always drawn with one offset.
module palette_pixel_pipe #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int IDX_W       = 8,
    parameter int COLOR_W     = 24,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(FB_W * FB_H)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               pix_valid,
    input  logic [ADDR_W-1:0]  scroll_x,
    input  logic [ADDR_W-1:0]  scroll_y,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               pal_we,
    input  logic [IDX_W-1:0]   pal_waddr,
    input  logic [COLOR_W-1:0] pal_wdata,
    output logic [ADDR_W-1:0]  fb_addr,
    input  logic [IDX_W-1:0]   fb_data,
    output logic [COLOR_W-1:0] color,
    output logic               color_valid
);

    localparam int CW       = ADDR_W + 1;
    localparam int PAL_D    = 1 << IDX_W;
    localparam int X_WRAPS  = (1024 >> SCALE_SHIFT) / FB_W + 1;
    localparam int Y_WRAPS  = (1024 >> SCALE_SHIFT) / FB_H + 1;
    localparam bit TRANSP_EN = (TRANSP_IDX >= 0) && (TRANSP_IDX < PAL_D);
    localparam logic [IDX_W-1:0] TRANSP_VAL = IDX_W'(TRANSP_IDX);

    logic               frame_q;
    logic               frame_rise;
    logic [ADDR_W-1:0]  sx;
    logic [ADDR_W-1:0]  sy;

    logic [CW-1:0]      sc_x;
    logic [CW-1:0]      sc_y;
    logic [CW-1:0]      tx;
    logic [CW-1:0]      ty;
    logic [CW-1:0]      lin_addr;
    logic               blank_next;

    logic               v1;
    logic               blank1;
    logic               v2;
    logic               blank2;
    logic [IDX_W-1:0]   idx;

    logic [COLOR_W-1:0] pal [0:PAL_D-1];

    assign frame_rise = frame_clk & ~frame_q;

    // Out-of-range scroll requests are ignored per axis so addresses stay inside the framebuffer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
            sx      <= '0;
            sy      <= '0;
        end else begin
            frame_q <= frame_clk;
            if (frame_rise) begin
                if (scroll_x < ADDR_W'(FB_W))
                    sx <= scroll_x;
                if (scroll_y < ADDR_W'(FB_H))
                    sy <= scroll_y;
            end
        end
    end

    // Blanking coordinates can scale past the framebuffer edge, so reduce them before adding scroll.
    always_comb begin
        sc_x = CW'(DrawX >> SCALE_SHIFT);
        sc_y = CW'(DrawY >> SCALE_SHIFT);
        for (int i = 0; i < X_WRAPS; i++) begin
            if (sc_x >= CW'(FB_W))
                sc_x = sc_x - CW'(FB_W);
        end
        for (int i = 0; i < Y_WRAPS; i++) begin
            if (sc_y >= CW'(FB_H))
                sc_y = sc_y - CW'(FB_H);
        end
        tx = sc_x + {1'b0, sx};
        if (tx >= CW'(FB_W))
            tx = tx - CW'(FB_W);
        ty = sc_y + {1'b0, sy};
        if (ty >= CW'(FB_H))
            ty = ty - CW'(FB_H);
        lin_addr   = ty * CW'(FB_W) + tx;
        blank_next = (int'(DrawX) >= H_RES) || (int'(DrawY) >= V_RES);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_addr <= '0;
            v1      <= 1'b0;
            blank1  <= 1'b0;
        end else begin
            fb_addr <= ADDR_W'(lin_addr);
            v1      <= pix_valid;
            blank1  <= blank_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx    <= '0;
            v2     <= 1'b0;
            blank2 <= 1'b0;
        end else begin
            idx    <= fb_data;
            v2     <= v1;
            blank2 <= blank1;
        end
    end

    // Palette is host-loaded and deliberately not cleared by reset.
    always_ff @(posedge Clk) begin
        if (pal_we)
            pal[pal_waddr] <= pal_wdata;
    end

    // The palette read here sees the pre-write entry when a write lands on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color       <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= v2;
            if (v2) begin
                if (blank2)
                    color <= '0;
                else if (TRANSP_EN && (idx == TRANSP_VAL))
                    color <= bg_color;
                else
                    color <= pal[idx];
            end
        end
    end

endmodule

// File: tb/tb_palette_pixel_pipe.sv
// Scoreboard bench for palette_pixel_pipe: stimulus pushes expected colours, a negedge monitor pops them.
module tb_palette_pixel_pipe;

    localparam int ADDR_W  = 17;
    localparam int IDX_W   = 8;
    localparam int COLOR_W = 24;
    localparam int FB_SIZE = 76800;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               frame_clk = 1'b0;
    logic [9:0]         DrawX = '0;
    logic [9:0]         DrawY = '0;
    logic               pix_valid = 1'b0;
    logic [ADDR_W-1:0]  scroll_x = '0;
    logic [ADDR_W-1:0]  scroll_y = '0;
    logic [COLOR_W-1:0] bg_color = 24'h00FF00;
    logic               pal_we = 1'b0;
    logic [IDX_W-1:0]   pal_waddr = '0;
    logic [COLOR_W-1:0] pal_wdata = '0;
    logic [ADDR_W-1:0]  fb_addr;
    logic [IDX_W-1:0]   fb_data;
    logic [COLOR_W-1:0] color;
    logic               color_valid;

    logic [IDX_W-1:0]   fbmem [0:FB_SIZE-1];

    typedef struct {
        logic [COLOR_W-1:0] col;
        int                 cyc;
        int                 tag;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    palette_pixel_pipe dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_valid   (pix_valid),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .bg_color    (bg_color),
        .pal_we      (pal_we),
        .pal_waddr   (pal_waddr),
        .pal_wdata   (pal_wdata),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .color       (color),
        .color_valid (color_valid)
    );

    // The registered fb_addr acts as the frameRAM address register.
    assign fb_data = (int'(fb_addr) < FB_SIZE) ? fbmem[fb_addr] : '0;

    always #10 Clk = ~Clk;

    always @(posedge Clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                                 input logic [ADDR_W-1:0] exp_addr,
                                 input logic [COLOR_W-1:0] exp_col, input int tag);
        exp_t e;
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        pix_valid = 1'b1;
        @(posedge Clk);
        #1;
        e.col = exp_col;
        e.cyc = cycle;
        e.tag = tag;
        sb.push_back(e);
        checkOutput($sformatf("pixel%0d addr", tag), 32'(fb_addr), 32'(exp_addr));
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        pix_valid = 1'b0;
        repeat (n - 1) @(negedge Clk);
    endtask

    task automatic writePal(input logic [IDX_W-1:0] a, input logic [COLOR_W-1:0] d);
        @(negedge Clk);
        pix_valid = 1'b0;
        pal_we = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
        @(negedge Clk);
        pal_we = 1'b0;
    endtask

    task automatic frameEdge(input logic [ADDR_W-1:0] nx, input logic [ADDR_W-1:0] ny);
        @(negedge Clk);
        pix_valid = 1'b0;
        scroll_x = nx;
        scroll_y = ny;
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
    endtask

    task automatic doReset();
        @(negedge Clk);
        pix_valid = 1'b0;
        Reset = 1'b1;
        sb.delete();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest expectation, exactly 2 cycles after issue.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (color_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected color_valid: got color %0h, expected no output", color);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("pixel%0d color", e.tag), 32'(color), 32'(e.col));
                checkOutput($sformatf("pixel%0d latency", e.tag), 32'(cycle - e.cyc), 32'd2);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < FB_SIZE; i++) fbmem[i] = '0;
        fbmem[322]   = 8'h09;
        fbmem[1605]  = 8'h05;
        fbmem[3230]  = 8'h03;
        fbmem[3260]  = 8'h04;
        fbmem[6460]  = 8'h05;
        fbmem[76681] = 8'h03;
        fbmem[3210]  = 8'h00;
        fbmem[0]     = 8'h09;
        fbmem[319]   = 8'h09;
        fbmem[1]     = 8'h07;

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        checkOutput("reset fb_addr", 32'(fb_addr), 32'd0);
        checkOutput("reset color", 32'(color), 32'd0);
        checkOutput("reset color_valid", 32'(color_valid), 32'd0);

        writePal(8'h09, 24'hFF0000);
        writePal(8'h03, 24'h123456);
        writePal(8'h05, 24'h0000FF);
        writePal(8'h04, 24'hC0FFEE);
        writePal(8'h07, 24'hAAAAAA);

        $display("[TB] latency and mapping");
        applyStimulus(10'd5, 10'd3, 17'd322, 24'hFF0000, 1);
        idle(4);
        checkOutput("bubble color hold", 32'(color), 32'hFF0000);
        checkOutput("bubble color_valid", 32'(color_valid), 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(10'd10, 10'd10, 17'd1605, 24'h0000FF, 2);
        applyStimulus(10'd10, 10'd10, 17'd1605, 24'h0000FF, 3);
        doReset();
        checkOutput("reset mid fb_addr", 32'(fb_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset mid color_valid c%0d", i), 32'(color_valid), 32'd0);
            checkOutput($sformatf("reset mid color c%0d", i), 32'(color), 32'd0);
            @(negedge Clk);
        end

        $display("[TB] scroll wrap and timing");
        frameEdge(17'd300, 17'd230);
        applyStimulus(10'd100, 10'd40, 17'd3230, 24'h123456, 4);
        idle(1);
        scroll_x = 17'd10;
        idle(2);
        applyStimulus(10'd100, 10'd40, 17'd3230, 24'h123456, 5);
        frameEdge(17'd10, 17'd230);
        applyStimulus(10'd100, 10'd40, 17'd3260, 24'hC0FFEE, 6);
        frameEdge(17'd320, 17'd0);
        applyStimulus(10'd100, 10'd40, 17'd6460, 24'h0000FF, 7);
        applyStimulus(10'd1023, 10'd479, 17'd76681, 24'h000000, 8);

        $display("[TB] transparency and blanking");
        frameEdge(17'd0, 17'd0);
        applyStimulus(10'd20, 10'd20, 17'd3210, 24'h00FF00, 9);
        applyStimulus(10'd640, 10'd0, 17'd0, 24'h000000, 10);
        applyStimulus(10'd639, 10'd0, 17'd319, 24'hFF0000, 11);
        applyStimulus(10'd0, 10'd480, 17'd0, 24'h000000, 12);

        $display("[TB] palette write collision");
        applyStimulus(10'd2, 10'd0, 17'd1, 24'hAAAAAA, 13);
        @(negedge Clk);
        pix_valid = 1'b0;
        @(negedge Clk);
        pal_we = 1'b1;
        pal_waddr = 8'h07;
        pal_wdata = 24'hBBBBBB;
        @(negedge Clk);
        pal_we = 1'b0;
        applyStimulus(10'd2, 10'd0, 17'd1, 24'hBBBBBB, 14);
        idle(6);

        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
